// File: rtl/memory_responder.sv
// Purpose : word-addressed RAM answering one-cycle read/write pulses from the control unit, plus a preload port.
// Latency : read data + read_valid arrive WAIT_STATES+1 cycles after the accepting edge; writes commit at that edge.
// Backpress: busy is high for WAIT_STATES cycles per request; requests or loads arriving while not IDLE are dropped and flag error.
//
// Ports:
//   clk, reset (async, active low)
//   RAM_enable_read / RAM_enable_write, address, write_data : request side (MAR/MDR)
//   read_data, read_valid                                   : response to MDR
//   busy, error, error_clear                                : status and sticky error handling
//   load_enable, load_address, load_data                    : program-image preload
module memory_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RAM_enable_read,
    input  logic                  RAM_enable_write,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_valid,
    output logic                  busy,
    output logic                  error,
    input  logic                  error_clear,
    input  logic                  load_enable,
    input  logic [ADDR_WIDTH-1:0] load_address,
    input  logic [DATA_WIDTH-1:0] load_data
);

    localparam int                  IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = DEPTH[ADDR_WIDTH:0];
    // Counter start value; only meaningful when WAIT_STATES > 0.
    localparam logic [3:0]          WAIT_LOAD = WAIT_STATES[3:0] - 4'd1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state;
    state_t                next_state;
    logic [3:0]            wait_cnt;
    logic                  op_read;
    logic [DATA_WIDTH-1:0] hold_data;

    logic                  is_idle;
    logic                  any_req;
    logic                  accept;
    logic                  addr_ok;
    logic                  load_ok;
    logic                  load_take;
    logic                  error_event;
    logic [IDX_W-1:0]      req_idx;
    logic [IDX_W-1:0]      load_idx;
    logic [DATA_WIDTH-1:0] rd_word;

    logic                  mem_we;
    logic [IDX_W-1:0]      mem_widx;
    logic [DATA_WIDTH-1:0] mem_wdat;

    // Request decode. Exactly one of read/write is a legal request; both
    // together is a protocol error and performs no access.
    always_comb begin
        is_idle   = (state == ST_IDLE);
        any_req   = RAM_enable_read | RAM_enable_write;
        accept    = is_idle && (RAM_enable_read ^ RAM_enable_write);
        addr_ok   = ({1'b0, address} < DEPTH_LIM);
        load_ok   = ({1'b0, load_address} < DEPTH_LIM);
        // A request in the same cycle always wins over the preload port.
        load_take = is_idle && load_enable && !any_req;
        req_idx   = address[IDX_W-1:0];
        load_idx  = load_address[IDX_W-1:0];
        // Out-of-range reads return zero with normal timing.
        rd_word   = addr_ok ? mem[req_idx] : '0;

        error_event = (is_idle && RAM_enable_read && RAM_enable_write)
                    | (accept && !addr_ok)
                    | (!is_idle && any_req)
                    | (load_enable && !load_take)
                    | (load_take && !load_ok);
    end

    // Single write port shared by request writes and preload; the two are
    // mutually exclusive because load_take requires no request.
    always_comb begin
        mem_we   = 1'b0;
        mem_widx = req_idx;
        mem_wdat = write_data;
        if (accept && RAM_enable_write && addr_ok) begin
            mem_we = 1'b1;
        end else if (load_take && load_ok) begin
            mem_we   = 1'b1;
            mem_widx = load_idx;
            mem_wdat = load_data;
        end
    end

    // Array is never reset so a preloaded image survives a processor reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wdat;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM: next state. Zero-wait writes never leave IDLE, so a read can
    // follow a write on the very next cycle.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        next_state = RAM_enable_read ? ST_RESP : ST_IDLE;
                    end else begin
                        next_state = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    next_state = op_read ? ST_RESP : ST_IDLE;
                end
            end
            ST_RESP: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // FSM: outputs. Both are decodes of the state flop, so read_valid is a
    // clean registered one-cycle strobe (RESP is only entered for reads).
    always_comb begin
        busy       = (state == ST_WAIT);
        read_valid = (state == ST_RESP);
    end

    // Datapath: wait counter, captured read word, returned data, sticky error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt  <= 4'd0;
            op_read   <= 1'b0;
            hold_data <= '0;
            read_data <= '0;
            error     <= 1'b0;
        end else begin
            if (accept) begin
                op_read  <= RAM_enable_read;
                wait_cnt <= WAIT_LOAD;
            end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end

            // The word is sampled at the accepting edge; with wait states it
            // is parked in hold_data and released as RESP is entered.
            if (accept && RAM_enable_read) begin
                if (WAIT_STATES == 0) begin
                    read_data <= rd_word;
                end else begin
                    hold_data <= rd_word;
                end
            end else if (state == ST_WAIT && wait_cnt == 4'd0 && op_read) begin
                read_data <= hold_data;
            end

            // A new error event in the same cycle beats error_clear.
            if (error_event) begin
                error <= 1'b1;
            end else if (error_clear) begin
                error <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_memory_responder.sv
// Purpose : self-checking bench for memory_responder (zero-wait/DEPTH=128 and three-wait/DEPTH=256 instances).
// Latency : all stimulus advances on the falling edge; outputs are sampled on the falling edge.
// Backpress: read data is checked through per-instance scoreboards fed at drive time.
module tb_memory_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Instance A: WAIT_STATES=0, DEPTH=128
    logic        a_rd, a_wr, a_clr, a_ld;
    logic [7:0]  a_addr, a_laddr;
    logic [15:0] a_wdata, a_ldata, a_rdata;
    logic        a_rv, a_busy, a_err;

    // Instance B: WAIT_STATES=3, DEPTH=256
    logic        b_rd, b_wr, b_clr, b_ld;
    logic [7:0]  b_addr, b_laddr;
    logic [15:0] b_wdata, b_ldata, b_rdata;
    logic        b_rv, b_busy, b_err;

    memory_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .DEPTH(128), .WAIT_STATES(0)) dut_a (
        .clk(clk), .reset(reset),
        .RAM_enable_read(a_rd), .RAM_enable_write(a_wr),
        .address(a_addr), .write_data(a_wdata),
        .read_data(a_rdata), .read_valid(a_rv), .busy(a_busy),
        .error(a_err), .error_clear(a_clr),
        .load_enable(a_ld), .load_address(a_laddr), .load_data(a_ldata)
    );

    memory_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .DEPTH(256), .WAIT_STATES(3)) dut_b (
        .clk(clk), .reset(reset),
        .RAM_enable_read(b_rd), .RAM_enable_write(b_wr),
        .address(b_addr), .write_data(b_wdata),
        .read_data(b_rdata), .read_valid(b_rv), .busy(b_busy),
        .error(b_err), .error_clear(b_clr),
        .load_enable(b_ld), .load_address(b_laddr), .load_data(b_ldata)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] qa[$];
    logic [15:0] qb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    endtask

    // Scoreboard monitors: every read_valid pops the oldest expected word.
    always @(negedge clk) begin
        if (a_rv) begin
            if (qa.size() != 0) check("a_read_data", {16'h0, a_rdata}, {16'h0, qa.pop_front()});
            else                check("a_unexpected_read_valid", {31'h0, a_rv}, 32'h0);
        end
        if (b_rv) begin
            if (qb.size() != 0) check("b_read_data", {16'h0, b_rdata}, {16'h0, qb.pop_front()});
            else                check("b_unexpected_read_valid", {31'h0, b_rv}, 32'h0);
        end
    end

    // Vector: op[0]=read, op[1]=write; addr/dat feed both request and load ports.
    typedef struct packed {
        logic [1:0]  op;
        logic        ld;
        logic        clr;
        logic [7:0]  addr;
        logic [15:0] dat;
        logic        exp_err;
        logic        exp_rv;
        logic [15:0] exp_data;
    } vec_t;

    localparam int NV = 36;
    vec_t vecs [NV];

    function automatic vec_t mkv(input logic [1:0] op, input logic ld, input logic clr,
                                 input logic [7:0] addr, input logic [15:0] dat,
                                 input logic e, input logic rv, input logic [15:0] ed);
        vec_t v;
        v.op = op; v.ld = ld; v.clr = clr; v.addr = addr; v.dat = dat;
        v.exp_err = e; v.exp_rv = rv; v.exp_data = ed;
        return v;
    endfunction

    // One B request cycle: drive at falling edge, hold across one rising edge, then idle.
    task automatic b_step(input logic rd, input logic wr, input logic ld, input logic clr,
                          input logic [7:0] addr, input logic [15:0] dat);
        b_rd = rd; b_wr = wr; b_ld = ld; b_clr = clr;
        b_addr = addr; b_laddr = addr; b_wdata = dat; b_ldata = dat;
        @(posedge clk);
        @(negedge clk);
        b_rd = 1'b0; b_wr = 1'b0; b_ld = 1'b0; b_clr = 1'b0;
    endtask

    task automatic b_idle_check(input string name, input logic exp_busy, input logic exp_rv);
        b_step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        check({name, "_busy"}, {31'h0, b_busy}, {31'h0, exp_busy});
        check({name, "_rv"},   {31'h0, b_rv},   {31'h0, exp_rv});
    endtask

    localparam logic [1:0] N = 2'd0, R = 2'd1, W = 2'd2, B = 2'd3;

    initial begin
        reset = 1'b0;
        a_rd = 0; a_wr = 0; a_clr = 0; a_ld = 0; a_addr = 0; a_laddr = 0; a_wdata = 0; a_ldata = 0;
        b_rd = 0; b_wr = 0; b_clr = 0; b_ld = 0; b_addr = 0; b_laddr = 0; b_wdata = 0; b_ldata = 0;

        vecs[0]  = mkv(N, 1, 0, 8'h05, 16'hA5C3, 0, 0, 16'h0);
        vecs[1]  = mkv(N, 1, 0, 8'h11, 16'h0000, 0, 0, 16'h0);
        vecs[2]  = mkv(N, 1, 0, 8'h20, 16'h0F0F, 0, 0, 16'h0);
        vecs[3]  = mkv(N, 1, 0, 8'h06, 16'h0666, 0, 0, 16'h0);
        vecs[4]  = mkv(N, 1, 0, 8'h00, 16'h0000, 0, 0, 16'h0);
        vecs[5]  = mkv(R, 0, 0, 8'h05, 16'h0000, 0, 1, 16'hA5C3);
        vecs[6]  = mkv(N, 0, 0, 8'h00, 16'h0000, 0, 0, 16'h0);
        vecs[7]  = mkv(W, 0, 0, 8'h10, 16'h1234, 0, 0, 16'h0);
        vecs[8]  = mkv(R, 0, 0, 8'h10, 16'h0000, 0, 1, 16'h1234);
        vecs[9]  = mkv(N, 0, 0, 8'h00, 16'h0000, 0, 0, 16'h0);
        vecs[10] = mkv(R, 0, 0, 8'h11, 16'h0000, 0, 1, 16'h0000);
        vecs[11] = mkv(N, 0, 0, 8'h00, 16'h0000, 0, 0, 16'h0);
        vecs[12] = mkv(B, 0, 0, 8'h20, 16'h5555, 1, 0, 16'h0);
        vecs[13] = mkv(N, 0, 1, 8'h00, 16'h0000, 0, 0, 16'h0);
        vecs[14] = mkv(R, 0, 0, 8'h20, 16'h0000, 0, 1, 16'h0F0F);
        vecs[15] = mkv(N, 0, 0, 8'h00, 16'h0000, 0, 0, 16'h0);
        vecs[16] = mkv(W, 0, 0, 8'h80, 16'hFFFF, 1, 0, 16'h0);
        vecs[17] = mkv(N, 0, 1, 8'h00, 16'h0000, 0, 0, 16'h0);
        vecs[18] = mkv(R, 0, 0, 8'h80, 16'h0000, 1, 1, 16'h0000);
        vecs[19] = mkv(N, 0, 1, 8'h00, 16'h0000, 0, 0, 16'h0);
        vecs[20] = mkv(R, 1, 0, 8'h05, 16'h1111, 1, 1, 16'hA5C3);
        vecs[21] = mkv(N, 1, 1, 8'h06, 16'h9999, 1, 0, 16'h0);
        vecs[22] = mkv(N, 0, 1, 8'h00, 16'h0000, 0, 0, 16'h0);
        vecs[23] = mkv(R, 0, 0, 8'h05, 16'h0000, 0, 1, 16'hA5C3);
        vecs[24] = mkv(R, 0, 0, 8'h10, 16'h0000, 1, 0, 16'h0);
        vecs[25] = mkv(N, 0, 1, 8'h00, 16'h0000, 0, 0, 16'h0);
        vecs[26] = mkv(R, 0, 0, 8'h06, 16'h0000, 0, 1, 16'h0666);
        vecs[27] = mkv(N, 0, 0, 8'h00, 16'h0000, 0, 0, 16'h0);
        vecs[28] = mkv(W, 0, 0, 8'h7F, 16'hCAFE, 0, 0, 16'h0);
        vecs[29] = mkv(R, 0, 0, 8'h7F, 16'h0000, 0, 1, 16'hCAFE);
        vecs[30] = mkv(N, 0, 0, 8'h00, 16'h0000, 0, 0, 16'h0);
        vecs[31] = mkv(R, 0, 0, 8'h00, 16'h0000, 0, 1, 16'h0000);
        vecs[32] = mkv(N, 0, 0, 8'h00, 16'h0000, 0, 0, 16'h0);
        vecs[33] = mkv(B, 0, 1, 8'h30, 16'h0000, 1, 0, 16'h0);
        vecs[34] = mkv(N, 0, 1, 8'h00, 16'h0000, 0, 0, 16'h0);
        vecs[35] = mkv(N, 0, 0, 8'h00, 16'h0000, 0, 0, 16'h0);

        // Reset state
        repeat (2) @(negedge clk);
        check("a_reset_read_data", {16'h0, a_rdata}, 32'h0);
        check("a_reset_read_valid", {31'h0, a_rv}, 32'h0);
        check("a_reset_busy", {31'h0, a_busy}, 32'h0);
        check("a_reset_error", {31'h0, a_err}, 32'h0);
        check("b_reset_read_data", {16'h0, b_rdata}, 32'h0);
        check("b_reset_busy", {31'h0, b_busy}, 32'h0);
        check("b_reset_error", {31'h0, b_err}, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // Table-driven run on instance A
        for (int i = 0; i < NV; i++) begin
            a_rd = vecs[i].op[0]; a_wr = vecs[i].op[1];
            a_ld = vecs[i].ld;    a_clr = vecs[i].clr;
            a_addr = vecs[i].addr; a_laddr = vecs[i].addr;
            a_wdata = vecs[i].dat; a_ldata = vecs[i].dat;
            if (vecs[i].exp_rv) qa.push_back(vecs[i].exp_data);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d_error", i), {31'h0, a_err}, {31'h0, vecs[i].exp_err});
            check($sformatf("vec%0d_read_valid", i), {31'h0, a_rv}, {31'h0, vecs[i].exp_rv});
            check($sformatf("vec%0d_busy", i), {31'h0, a_busy}, 32'h0);
        end
        a_rd = 0; a_wr = 0; a_ld = 0; a_clr = 0;

        // Instance B: preload, then a write holds busy for three cycles
        b_step(1'b0, 1'b0, 1'b1, 1'b0, 8'h05, 16'hA5C3);
        check("b_preload_error", {31'h0, b_err}, 32'h0);
        b_step(1'b0, 1'b1, 1'b0, 1'b0, 8'h40, 16'hBEEF);
        check("b_wr_c1_busy", {31'h0, b_busy}, 32'h1);
        b_idle_check("b_wr_c2", 1'b1, 1'b0);
        b_idle_check("b_wr_c3", 1'b1, 1'b0);
        b_idle_check("b_wr_c4", 1'b0, 1'b0);

        // Read with 3 wait states; a second pulse sampled at E+2 is ignored
        qb.push_back(16'hA5C3);
        b_step(1'b1, 1'b0, 1'b0, 1'b0, 8'h05, 16'h0000);
        check("b_rd_c1_busy", {31'h0, b_busy}, 32'h1);
        check("b_rd_c1_rv", {31'h0, b_rv}, 32'h0);
        b_idle_check("b_rd_c2", 1'b1, 1'b0);
        b_step(1'b1, 1'b0, 1'b0, 1'b0, 8'h40, 16'h0000);
        check("b_rd_c3_busy", {31'h0, b_busy}, 32'h1);
        check("b_rd_ignored_error", {31'h0, b_err}, 32'h1);
        b_idle_check("b_rd_c4", 1'b0, 1'b1);
        check("b_rd_c4_data", {16'h0, b_rdata}, 32'h0000A5C3);
        b_idle_check("b_rd_c5", 1'b0, 1'b0);
        b_step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'h0000);
        check("b_error_clear", {31'h0, b_err}, 32'h0);

        // Reset during WAIT aborts the read; the earlier write survives
        b_step(1'b1, 1'b0, 1'b0, 1'b0, 8'h05, 16'h0000);
        b_step(1'b1, 1'b0, 1'b0, 1'b0, 8'h05, 16'h0000);
        check("b_pre_reset_busy", {31'h0, b_busy}, 32'h1);
        check("b_pre_reset_error", {31'h0, b_err}, 32'h1);
        #2 reset = 1'b0;
        #1;
        check("b_async_reset_busy", {31'h0, b_busy}, 32'h0);
        check("b_async_reset_error", {31'h0, b_err}, 32'h0);
        check("b_async_reset_rv", {31'h0, b_rv}, 32'h0);
        check("b_async_reset_data", {16'h0, b_rdata}, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 6; k++) b_idle_check($sformatf("b_post_reset%0d", k), 1'b0, 1'b0);

        qb.push_back(16'hBEEF);
        b_step(1'b1, 1'b0, 1'b0, 1'b0, 8'h40, 16'h0000);
        b_idle_check("b_rd40_c2", 1'b1, 1'b0);
        b_idle_check("b_rd40_c3", 1'b1, 1'b0);
        b_idle_check("b_rd40_c4", 1'b0, 1'b1);
        b_idle_check("b_rd40_c5", 1'b0, 1'b0);

        check("a_scoreboard_empty", qa.size(), 32'h0);
        check("b_scoreboard_empty", qb.size(), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
